inst_fetch_ctrl: RTL and testbench
==================================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'hBFC0_0000, PC loaded at reset.
REQ-002 Clock and reset ports: clk input 1, rising-edge clock; rst input 1, reset.
REQ-003 Reset is asynchronous and active-low; one clock domain only.
REQ-004 Redirect ports: redirect_valid input 1, redirect request; redirect_pc input 32, redirect target.
REQ-005 FIFO back-pressure port: fifo_full input 1, the inst_fifo full flag.
REQ-006 I-cache request ports: inst_req output 1, request valid; inst_addr output 32, request address; inst_addr_ok input 1, request accepted.
REQ-007 I-cache return ports: inst_data_ok input 1, data return; inst_rdata input 64, 8-byte-aligned instruction pair, low word at the lower address.
REQ-008 FIFO write ports: write_en1 output 1, slot-1 write; write_en2 output 1, slot-2 write.
REQ-009 FIFO data ports: write_address1 output 32, slot-1 PC; write_address2 output 32, slot-2 PC; write_data1 output 32, slot-1 instruction; write_data2 output 32, slot-2 instruction.
REQ-010 Status ports: inst_enF2 output 1, written entry valid (0 = fetch address error); fetch_halt output 1, halted on address error; fetch_cnt output 32, count of instructions written.

Function
REQ-011 FSM states: RUN (no outstanding request), WAIT (one accepted request outstanding), DISCARD (outstanding response to be dropped).
REQ-012 At most one request is outstanding at any time.
REQ-013 inst_req = (state==RUN) & !fifo_full & !fetch_halt & !redirect_valid & (pc[1:0]==0); inst_req is combinational.
REQ-014 inst_addr = {pc[31:3],3'b000}.
REQ-015 On inst_req & inst_addr_ok: latch req_pc=pc; pc <= {pc[31:3],3'b000}+8; go to WAIT.
REQ-016 In WAIT, inst_data_ok with no redirect: write_en1=1 in the same cycle (combinational from inst_data_ok); go to RUN.
REQ-017 If req_pc[2]==0: write_en2=1; data1=rdata[31:0]; data2=rdata[63:32]; address1=req_pc; address2=req_pc+4.
REQ-018 If req_pc[2]==1: write_en2=0; data1=rdata[63:32]; address1=req_pc.
REQ-019 redirect_valid in any state: pc <= redirect_pc next cycle; fetch_halt cleared.
REQ-020 Redirect in RUN with a same-cycle accepted request -> DISCARD.
REQ-021 Redirect in WAIT without inst_data_ok -> DISCARD.
REQ-022 Redirect in WAIT with inst_data_ok in the same cycle: data dropped, no write; -> RUN.
REQ-023 Redirect in DISCARD: stay in DISCARD, unless inst_data_ok occurs in the same cycle -> RUN.
REQ-024 In DISCARD, inst_data_ok: no write; -> RUN.
REQ-025 Minimum redirect-to-request latency: 1 cycle (redirect at N, inst_req with new address at N+1 if in RUN).
REQ-026 Address error: state RUN, pc[1:0]!=0, !fifo_full, no redirect -> no cache request; write_en1=1, inst_enF2=0, write_address1=pc, write_data1=0, write_en2=0; fetch_halt <= 1.
REQ-027 While fetch_halt=1, no requests or writes occur until redirect_valid.
REQ-028 inst_enF2=1 on every normal write; write_* outputs are 0 when write_en1=0.
REQ-029 fifo_full only gates new requests; an outstanding response is always written (the FIFO guarantees 2 free slots while not full).
REQ-030 fetch_cnt += write_en1+write_en2 on each cycle (address-error writes included); it wraps modulo 2^32.

Reset
REQ-031 Asynchronous assertion (rst=0) sets: state=RUN, pc=RESET_PC, req_pc=0, fetch_halt=0, fetch_cnt=0.
REQ-032 During reset, inst_req and both write_en outputs are 0; reset mid-WAIT forgets the outstanding request, and any later inst_data_ok arriving in RUN is ignored.
REQ-033 Deassertion is clock-synchronous; the first inst_req, for RESET_PC, appears in the first cycle after deassertion with fifo_full=0.

Verification
REQ-034 Reset release, addr_ok=1, data_ok next cycle, rdata=64'h2222_2222_1111_1111 -> write_en1=1/write_en2=1, addr1=BFC0_0000/data1=1111_1111, addr2=BFC0_0004/data2=2222_2222, fetch_cnt=2.
REQ-035 Redirect to 0x8000_0004, then a response -> inst_addr=8000_0000, write_en2=0, data1=rdata[63:32], addr1=8000_0004; next inst_addr=8000_0008.
REQ-036 Redirect to 0x8000_0100 in WAIT, data_ok two cycles later -> no write on that data_ok; next inst_addr=8000_0100.
REQ-037 Redirect and data_ok in the same WAIT cycle -> no write, state RUN, inst_req for the redirect target next cycle.
REQ-038 fifo_full=1 held 5 cycles in RUN -> inst_req=0 throughout; an outstanding response still written; requests resume the cycle fifo_full drops.
REQ-039 Redirect to 0x8000_0002 -> one write with inst_enF2=0, addr1=8000_0002, fetch_halt=1, no inst_req until the next redirect.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues one 8-byte-aligned I-cache request at
// a time, splits each returned instruction pair into up to two FIFO writes,
// drops responses made stale by a redirect, and halts on a misaligned PC.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fifo_full,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [63:0] inst_rdata,
    output logic        write_en1,
    output logic        write_en2,
    output logic [31:0] write_address1,
    output logic [31:0] write_address2,
    output logic [31:0] write_data1,
    output logic [31:0] write_data2,
    output logic        inst_enF2,
    output logic        fetch_halt,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_fetch_halt;
    logic [31:0] r_fetch_cnt;

    logic        w_idle;
    logic        w_addr_err;
    logic        w_accept;
    logic        w_deliver;
    logic [31:0] w_pc_line;

    // Outputs are gated by rst so nothing is requested or written while the
    // block is held in reset (the reset PC would otherwise look issuable).
    assign w_pc_line  = {r_pc[31:3], 3'b000};
    assign w_idle     = rst && (r_state == ST_RUN) && !fifo_full
                        && !r_fetch_halt && !redirect_valid;
    assign inst_req   = w_idle && (r_pc[1:0] == 2'b00);
    assign w_addr_err = w_idle && (r_pc[1:0] != 2'b00);
    assign w_accept   = inst_req && inst_addr_ok;
    assign w_deliver  = rst && (r_state == ST_WAIT) && inst_data_ok && !redirect_valid;
    assign inst_addr  = w_pc_line;
    assign fetch_halt = r_fetch_halt;
    assign fetch_cnt  = r_fetch_cnt;

    // Next-state selection for the request/response tracker.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    w_state_next = redirect_valid ? ST_DISCARD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    w_state_next = ST_RUN;
                end else if (redirect_valid) begin
                    w_state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (inst_data_ok) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // FIFO write port: a delivered pair (one or two slots, depending on
    // whether the fetch started on the upper word) or a single error entry.
    always_comb begin
        write_en1      = 1'b0;
        write_en2      = 1'b0;
        write_address1 = 32'd0;
        write_address2 = 32'd0;
        write_data1    = 32'd0;
        write_data2    = 32'd0;
        inst_enF2      = 1'b0;
        if (w_deliver) begin
            write_en1      = 1'b1;
            inst_enF2      = 1'b1;
            write_address1 = r_req_pc;
            if (!r_req_pc[2]) begin
                write_en2      = 1'b1;
                write_data1    = inst_rdata[31:0];
                write_data2    = inst_rdata[63:32];
                write_address2 = r_req_pc + 32'd4;
            end else begin
                write_data1    = inst_rdata[63:32];
            end
        end else if (w_addr_err) begin
            write_en1      = 1'b1;
            write_address1 = r_pc;
        end
    end

    // State, PC, halt flag and instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_req_pc     <= 32'd0;
            r_fetch_halt <= 1'b0;
            r_fetch_cnt  <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_fetch_cnt <= r_fetch_cnt + {31'd0, write_en1} + {31'd0, write_en2};
            if (w_accept) begin
                r_req_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_accept) begin
                r_pc <= w_pc_line + 32'd8;
            end
            if (redirect_valid) begin
                r_fetch_halt <= 1'b0;
            end else if (w_addr_err) begin
                r_fetch_halt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed vector table, a reset-mid-request
// sequence, then randomized traffic against a transaction-level model.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fifo_full;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [63:0] inst_rdata;
    logic        write_en1;
    logic        write_en2;
    logic [31:0] write_address1;
    logic [31:0] write_address2;
    logic [31:0] write_data1;
    logic [31:0] write_data2;
    logic        inst_enF2;
    logic        fetch_halt;
    logic [31:0] fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_full      (fifo_full),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .write_en1      (write_en1),
        .write_en2      (write_en2),
        .write_address1 (write_address1),
        .write_address2 (write_address2),
        .write_data1    (write_data1),
        .write_data2    (write_data2),
        .inst_enF2      (inst_enF2),
        .fetch_halt     (fetch_halt),
        .fetch_cnt      (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        full;
        logic        aok;
        logic        dok;
        logic [63:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we1;
        logic        e_we2;
        logic [31:0] e_a1;
        logic [31:0] e_d1;
        logic [31:0] e_a2;
        logic [31:0] e_d2;
        logic        e_en;
        logic        e_halt;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic redir, input logic [31:0] rpc, input logic full,
        input logic aok, input logic dok, input logic [63:0] rdata,
        input logic e_req, input logic [31:0] e_addr,
        input logic e_we1, input logic e_we2,
        input logic [31:0] e_a1, input logic [31:0] e_d1,
        input logic [31:0] e_a2, input logic [31:0] e_d2,
        input logic e_en, input logic e_halt, input logic [31:0] e_cnt);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.full = full; v.aok = aok; v.dok = dok;
        v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_we1 = e_we1;
        v.e_we2 = e_we2; v.e_a1 = e_a1; v.e_d1 = e_d1; v.e_a2 = e_a2;
        v.e_d2 = e_d2; v.e_en = e_en; v.e_halt = e_halt; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag,
        input logic e_req, input logic [31:0] e_addr,
        input logic e_we1, input logic e_we2,
        input logic [31:0] e_a1, input logic [31:0] e_d1,
        input logic [31:0] e_a2, input logic [31:0] e_d2,
        input logic e_en, input logic e_halt, input logic [31:0] e_cnt);
        check({tag, ".inst_req"},   {63'd0, inst_req},   {63'd0, e_req});
        check({tag, ".inst_addr"},  {32'd0, inst_addr},  {32'd0, e_addr});
        check({tag, ".write_en1"},  {63'd0, write_en1},  {63'd0, e_we1});
        check({tag, ".write_en2"},  {63'd0, write_en2},  {63'd0, e_we2});
        check({tag, ".addr1"},      {32'd0, write_address1}, {32'd0, e_a1});
        check({tag, ".data1"},      {32'd0, write_data1},    {32'd0, e_d1});
        check({tag, ".addr2"},      {32'd0, write_address2}, {32'd0, e_a2});
        check({tag, ".data2"},      {32'd0, write_data2},    {32'd0, e_d2});
        check({tag, ".inst_enF2"},  {63'd0, inst_enF2},  {63'd0, e_en});
        check({tag, ".fetch_halt"}, {63'd0, fetch_halt}, {63'd0, e_halt});
        check({tag, ".fetch_cnt"},  {32'd0, fetch_cnt},  {32'd0, e_cnt});
    endtask

    task automatic drive(input logic redir, input logic [31:0] rpc, input logic full,
                         input logic aok, input logic dok, input logic [63:0] rdata);
        redirect_valid = redir;
        redirect_pc    = rpc;
        fifo_full      = full;
        inst_addr_ok   = aok;
        inst_data_ok   = dok;
        inst_rdata     = rdata;
    endtask

    // Transaction-level reference model state
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    logic        m_halt;
    logic        m_pending;
    logic        m_stale;
    logic [31:0] m_cnt;

    initial begin
        // Directed table: reset-release fetch, redirects, back-pressure, address error
        vecs[0]  = mk(0, 0, 0, 1, 0, 64'd0, 1, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 1, 64'h2222_2222_1111_1111, 0, 32'hBFC0_0008,
                      1, 1, 32'hBFC0_0000, 32'h1111_1111, 32'hBFC0_0004, 32'h2222_2222, 1, 0, 0);
        vecs[2]  = mk(1, 32'h8000_0004, 0, 1, 0, 64'd0, 0, 32'hBFC0_0008, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        vecs[3]  = mk(0, 0, 0, 1, 0, 64'd0, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        vecs[4]  = mk(0, 0, 0, 0, 1, 64'hAAAA_AAAA_5555_5555, 0, 32'h8000_0008,
                      1, 0, 32'h8000_0004, 32'hAAAA_AAAA, 0, 0, 1, 0, 2);
        vecs[5]  = mk(0, 0, 0, 1, 0, 64'd0, 1, 32'h8000_0008, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[6]  = mk(1, 32'h8000_0100, 0, 0, 0, 64'd0, 0, 32'h8000_0010, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[7]  = mk(0, 0, 0, 0, 0, 64'd0, 0, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[8]  = mk(0, 0, 0, 0, 1, 64'hDEAD_BEEF_CAFE_F00D, 0, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[9]  = mk(0, 0, 0, 1, 0, 64'd0, 1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[10] = mk(1, 32'h8000_0200, 0, 0, 1, 64'h1234_5678_8765_4321, 0, 32'h8000_0108, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[11] = mk(0, 0, 0, 0, 0, 64'd0, 1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[12] = mk(0, 0, 0, 1, 0, 64'd0, 1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[13] = mk(0, 0, 1, 0, 0, 64'd0, 0, 32'h8000_0208, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        vecs[14] = mk(0, 0, 1, 0, 1, 64'h4444_4444_3333_3333, 0, 32'h8000_0208,
                      1, 1, 32'h8000_0200, 32'h3333_3333, 32'h8000_0204, 32'h4444_4444, 1, 0, 3);
        vecs[15] = mk(0, 0, 1, 1, 0, 64'd0, 0, 32'h8000_0208, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        vecs[16] = mk(0, 0, 1, 1, 0, 64'd0, 0, 32'h8000_0208, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        vecs[17] = mk(0, 0, 1, 1, 0, 64'd0, 0, 32'h8000_0208, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        vecs[18] = mk(0, 0, 0, 0, 0, 64'd0, 1, 32'h8000_0208, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        vecs[19] = mk(1, 32'h8000_0002, 0, 0, 0, 64'd0, 0, 32'h8000_0208, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        vecs[20] = mk(0, 0, 0, 0, 0, 64'd0, 0, 32'h8000_0000, 1, 0, 32'h8000_0002, 0, 0, 0, 0, 0, 5);
        vecs[21] = mk(0, 0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        vecs[22] = mk(0, 0, 0, 1, 1, 64'h0123_4567_89AB_CDEF, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        vecs[23] = mk(1, 32'h8000_0300, 0, 0, 0, 64'd0, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        vecs[24] = mk(0, 0, 0, 0, 0, 64'd0, 1, 32'h8000_0300, 0, 0, 0, 0, 0, 0, 0, 0, 6);

        // Held in reset: nothing requested or written
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset", 0, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("[TB] reset state checked");

        // Release reset; first table vector runs in the first cycle after release
        rst = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].redir, vecs[i].rpc, vecs[i].full, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
            #3;
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_we1,
                      vecs[i].e_we2, vecs[i].e_a1, vecs[i].e_d1, vecs[i].e_a2, vecs[i].e_d2,
                      vecs[i].e_en, vecs[i].e_halt, vecs[i].e_cnt);
            $display("[TB] vec %0d: req=%0b addr=%h we1=%0b we2=%0b cnt=%0d",
                     i, inst_req, inst_addr, write_en1, write_en2, fetch_cnt);
            @(posedge clk);
            #1;
        end

        // Reset while a request is outstanding; the late response must be ignored
        drive(0, 0, 0, 1, 0, 64'd0);
        #3;
        check("midwait.accept_req", {63'd0, inst_req}, 64'd1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 64'd0);
        rst = 1'b0;
        #1;
        inst_data_ok = 1'b1;
        inst_rdata   = 64'h5555_5555_6666_6666;
        #1;
        check("inreset.inst_req",  {63'd0, inst_req},  64'd0);
        check("inreset.write_en1", {63'd0, write_en1}, 64'd0);
        check("inreset.write_en2", {63'd0, write_en2}, 64'd0);
        check("inreset.fetch_cnt", {32'd0, fetch_cnt}, 64'd0);
        check("inreset.inst_addr", {32'd0, inst_addr}, 64'h0000_0000_BFC0_0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("late_rsp.write_en1", {63'd0, write_en1}, 64'd0);
        check("late_rsp.inst_req",  {63'd0, inst_req},  64'd1);
        check("late_rsp.inst_addr", {32'd0, inst_addr}, 64'h0000_0000_BFC0_0000);
        $display("[TB] reset mid-request: req=%0b we1=%0b", inst_req, write_en1);
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model (DUT now idle at RESET_PC)
        m_pc      = 32'hBFC0_0000;
        m_req_pc  = 32'd0;
        m_halt    = 1'b0;
        m_pending = 1'b0;
        m_stale   = 1'b0;
        m_cnt     = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            logic        redir;
            logic [31:0] rpc;
            logic        full;
            logic        aok;
            logic        dok;
            logic [63:0] rdata;
            logic        can_issue;
            logic        e_req;
            logic        e_err;
            logic        deliver;
            int          n;
            logic [31:0] ea[2];
            logic [31:0] ed[2];
            int          first_word;

            redir = ($urandom_range(0, 7) == 0);
            rpc   = $urandom;
            if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
            full  = ($urandom_range(0, 3) == 0);
            aok   = ($urandom_range(0, 1) == 1);
            dok   = m_pending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            rdata = {$urandom, $urandom};
            drive(redir, rpc, full, aok, dok, rdata);

            // Expected behaviour from the fetch rules
            can_issue = !m_pending && !m_halt && !full && !redir;
            e_req     = can_issue && (m_pc[1:0] == 2'b00);
            e_err     = can_issue && (m_pc[1:0] != 2'b00);
            deliver   = m_pending && !m_stale && dok && !redir;
            n = 0;
            ea[0] = 0; ea[1] = 0; ed[0] = 0; ed[1] = 0;
            if (deliver) begin
                first_word = m_req_pc[2] ? 1 : 0;
                for (int w = first_word; w < 2; w++) begin
                    ea[n] = {m_req_pc[31:3], 3'b000} + 32'(4 * w);
                    ed[n] = rdata[32*w +: 32];
                    n++;
                end
            end else if (e_err) begin
                ea[0] = m_pc;
                n = 1;
            end

            #3;
            check_all($sformatf("rnd%0d", c), e_req, {m_pc[31:3], 3'b000}, n >= 1, n == 2,
                      ea[0], ed[0], ea[1], ed[1], deliver, m_halt, m_cnt);
            if (write_en1 === 1'b1)
                $display("[TB] rnd %0d: write a1=%h d1=%h we2=%0b en=%0b", c,
                         write_address1, write_data1, write_en2, inst_enF2);

            // Advance the model
            m_cnt = m_cnt + 32'(n);
            if (m_pending && dok) begin
                m_pending = 1'b0;
                m_stale   = 1'b0;
            end else if (m_pending && redir) begin
                m_stale = 1'b1;
            end
            if (e_req && aok) begin
                m_pending = 1'b1;
                m_stale   = 1'b0;
                m_req_pc  = m_pc;
                m_pc      = {m_pc[31:3], 3'b000} + 32'd8;
            end
            if (redir) begin
                m_pc   = rpc;
                m_halt = 1'b0;
            end
            if (e_err) m_halt = 1'b1;

            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
